// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Build option: REGFILE_ZERO_REG_EN makes register 0 a hardwired zero.
package regfile_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;
  localparam int MAX_WR     = 4;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // LSB offset of port idx inside a flat bus of w-bit fields
  function automatic int sliceLsb(input int idx, input int w);
    return idx * w;
  endfunction

  // Highest set bit wins: higher write-port index has priority
  function automatic logic [1:0] winPort(input logic [MAX_WR-1:0] hit);
    winPort = '0;
    for (int k = 0; k < MAX_WR; k++)
      if (hit[k]) winPort = 2'(k);
  endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// One read port: storage mux, write bypass and bypass-qualified pending flag.
// Under REGFILE_ZERO_REG_EN, address 0 reads as 0 and never pending.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_WR = 1,
  localparam int NREGS = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0]              addr,
  input  logic [NREGS-1:0][DATA_W-1:0]   regs,
  input  logic [NREGS-1:0]               pending,
  input  logic [NUM_WR-1:0]              wrEff,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wrAddr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wrData,
  output logic [DATA_W-1:0]              rdData,
  output logic                           rdPending
);
  logic [NUM_WR-1:0] hit;
  logic [MAX_WR-1:0] hitExt;
  logic [1:0]        win;
  logic [DATA_W-1:0] byp;

  always_comb begin
    hit    = '0;
    hitExt = '0;
    byp    = '0;
    for (int w = 0; w < NUM_WR; w++)
      hit[w] = wrEff[w] && (wrAddr[w] == addr);
    hitExt[NUM_WR-1:0] = hit;
    win = winPort(hitExt);
    for (int w = 0; w < NUM_WR; w++)
      if (win == 2'(w)) byp = wrData[w];
    rdData    = (|hit) ? byp : regs[addr];
    // data arriving this cycle is valid, so no stall on it
    rdPending = pending[addr] & ~(|hit);
    if (ZERO_REG && addr == '0) begin
      rdData    = '0;
      rdPending = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write bypass and pending scoreboard.
// Build option: REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic                       busy_any
);
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0]  regs;
  logic [NREGS-1:0]              pending;
  logic [NUM_WR-1:0]             wrEff;
  logic [NUM_WR-1:0][ADDR_W-1:0] wrAddrV;
  logic [NUM_WR-1:0][DATA_W-1:0] wrDataV;
  logic                          rsvEff;

  // Writes are squashed while in reset so nothing bypasses to the read ports
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wrAddrV[w] = wr_addr[sliceLsb(w, ADDR_W) +: ADDR_W];
      wrDataV[w] = wr_data[sliceLsb(w, DATA_W) +: DATA_W];
      wrEff[w]   = wr_en[w] && rst && (!ZERO_REG || wrAddrV[w] != '0);
    end
    rsvEff = rsv_en && rst && (!ZERO_REG || rsv_addr != '0);
  end

  // Loop order gives the highest port the last word; reserve after clear keeps it pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wrEff[w]) begin
          regs[wrAddrV[w]]    <= wrDataV[w];
          pending[wrAddrV[w]] <= 1'b0;
        end
      end
      if (rsvEff) pending[rsv_addr] <= 1'b1;
    end
  end

  assign busy_any = |pending;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_rd (
      .addr     (rd_addr[sliceLsb(i, ADDR_W) +: ADDR_W]),
      .regs     (regs),
      .pending  (pending),
      .wrEff    (wrEff),
      .wrAddr   (wrAddrV),
      .wrData   (wrDataV),
      .rdData   (rd_data[sliceLsb(i, DATA_W) +: DATA_W]),
      .rdPending(rd_pending[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports) with a queue-based scoreboard.
// Expected values follow REGFILE_ZERO_REG_EN when it is defined.
module tb_regfile_mp;
  localparam int DW = 16, AW = 4, NR = 2, NW = 2;

  logic               clk, rst;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_pending;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*DW-1:0]   wr_data;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;
  logic               busy_any;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_any(busy_any)
  );

  typedef struct {
    string       name;
    logic [15:0] d0, d1;
    logic [1:0]  p;
    logic        b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, settled 3 time units after each drive
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (rd_data !== {e.d1, e.d0} || rd_pending !== e.p || busy_any !== e.b) begin
          bad++;
          $display("FAIL %s: got d1/d0=%h/%h pend=%b busy=%b, want d1/d0=%h/%h pend=%b busy=%b",
                   e.name, rd_data[31:16], rd_data[15:0], rd_pending, busy_any,
                   e.d1, e.d0, e.p, e.b);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rv, input logic [1:0] we,
                      input logic [3:0] wa0, input logic [15:0] wd0,
                      input logic [3:0] wa1, input logic [15:0] wd1,
                      input logic rs, input logic [3:0] ra,
                      input logic [3:0] r0, input logic [3:0] r1,
                      input logic [15:0] e0, input logic [15:0] e1,
                      input logic [1:0] ep, input logic eb);
    exp_t e;
    @(negedge clk);
    rst      = rv;
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rsv_en   = rs;
    rsv_addr = ra;
    rd_addr  = {r1, r0};
    e.name = nm; e.d0 = e0; e.d1 = e1; e.p = ep; e.b = eb;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    //    name          rst we    wa0 wd0       wa1 wd1       rsv ra  r0 r1  e0        e1        ep     eb
    step("rst_idle",    0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  0, 0,  16'h0000, 16'h0000, 2'b00, 0);
    step("pre_wr",      1, 2'b01, 3, 16'h0077, 0, 16'h0000, 1, 6,  3, 6,  16'h0077, 16'h0000, 2'b00, 0);
    step("pre_chk",     1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  3, 6,  16'h0077, 16'h0000, 2'b10, 1);
    step("rst_mid",     0, 2'b01, 3, 16'hBEEF, 0, 16'h0000, 0, 0,  3, 6,  16'h0000, 16'h0000, 2'b00, 0);
    step("rst_rel",     1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  3, 3,  16'h0000, 16'h0000, 2'b00, 0);
    step("wr5_byp",     1, 2'b01, 5, 16'h1234, 0, 16'h0000, 0, 0,  5, 5,  16'h1234, 16'h1234, 2'b00, 0);
    step("rd5",         1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  5, 5,  16'h1234, 16'h1234, 2'b00, 0);
    step("byp7",        1, 2'b01, 7, 16'hA5A5, 0, 16'h0000, 0, 0,  7, 5,  16'hA5A5, 16'h1234, 2'b00, 0);
    step("prio_byp",    1, 2'b11, 2, 16'h1111, 2, 16'h2222, 0, 0,  2, 7,  16'h2222, 16'hA5A5, 2'b00, 0);
    step("prio_st",     1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  2, 2,  16'h2222, 16'h2222, 2'b00, 0);
    step("rsv4",        1, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 4,  4, 4,  16'h0000, 16'h0000, 2'b00, 0);
    step("pend4",       1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  4, 4,  16'h0000, 16'h0000, 2'b11, 1);
    step("pend4b",      1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  4, 4,  16'h0000, 16'h0000, 2'b11, 1);
    step("wr4",         1, 2'b01, 4, 16'h0042, 0, 16'h0000, 0, 0,  4, 5,  16'h0042, 16'h1234, 2'b00, 1);
    step("clr4",        1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  4, 5,  16'h0042, 16'h1234, 2'b00, 0);
    step("rsvwr4",      1, 2'b10, 0, 16'h0000, 4, 16'h0099, 1, 4,  4, 4,  16'h0099, 16'h0099, 2'b00, 0);
    step("rsvwr4_chk",  1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  4, 4,  16'h0099, 16'h0099, 2'b11, 1);
    step("wr_nonpend",  1, 2'b10, 0, 16'h0000, 9, 16'h0009, 0, 0,  9, 4,  16'h0009, 16'h0099, 2'b10, 1);
    step("rersv",       1, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 4,  9, 4,  16'h0009, 16'h0099, 2'b10, 1);
    step("wr4_clr",     1, 2'b01, 4, 16'h0100, 0, 16'h0000, 0, 0,  9, 4,  16'h0009, 16'h0100, 2'b00, 1);
`ifdef REGFILE_ZERO_REG_EN
    step("zero_byp",    1, 2'b01, 0, 16'hFFFF, 0, 16'h0000, 1, 0,  0, 0,  16'h0000, 16'h0000, 2'b00, 0);
    step("zero_chk",    1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  0, 0,  16'h0000, 16'h0000, 2'b00, 0);
`else
    step("r0_byp",      1, 2'b01, 0, 16'hFFFF, 0, 16'h0000, 1, 0,  0, 0,  16'hFFFF, 16'hFFFF, 2'b00, 0);
    step("r0_chk",      1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0,  0, 0,  16'hFFFF, 16'hFFFF, 2'b11, 1);
`endif
    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
